// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin write-back arbiter and destination scoreboard
//    for the 64-entry unified register file (0-31 integer, 32-63 FP).
//
// Ports:
//    clk, rst_n              clock (rising edge), asynchronous active-low reset
//    wb_valid / wb_ready     per-producer result handshake (0 = ALU, 1 = FPU, 2 = LSU)
//    wb_addr0..2, wb_data0..2  destination and result of each producer
//    iss_valid / iss_addr    decode claims a destination register
//    iss_ready               claim accepted (destination has no pending write)
//    chk_addr1, chk_addr2    source operands checked for pending writes
//    raw_hazard              a source operand has a pending write
//    rf_we, rf_waddr, rf_wdata  registered register-file write port
module regfile_wb_arbiter #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 6,
   parameter int NREQ   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   wb_valid,
   output logic [NREQ-1:0]   wb_ready,
   input  logic [ADDR_W-1:0] wb_addr0,
   input  logic [ADDR_W-1:0] wb_addr1,
   input  logic [ADDR_W-1:0] wb_addr2,
   input  logic [DATA_W-1:0] wb_data0,
   input  logic [DATA_W-1:0] wb_data1,
   input  logic [DATA_W-1:0] wb_data2,
   input  logic              iss_valid,
   input  logic [ADDR_W-1:0] iss_addr,
   output logic              iss_ready,
   input  logic [ADDR_W-1:0] chk_addr1,
   input  logic [ADDR_W-1:0] chk_addr2,
   output logic              raw_hazard,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata
);
   localparam int NREG = 1 << ADDR_W;
   logic [1:0]        rr, gnt, p1, p2;
   logic              xfer;
   logic [ADDR_W-1:0] g_addr;
   logic [DATA_W-1:0] g_data;
   logic [NREG-1:0]   busy, set_m, clr_m;
   always_comb begin
      p1         = (rr == 2'd2) ? 2'd0 : rr + 2'd1;
      p2         = (rr == 2'd0) ? 2'd2 : rr - 2'd1;
      xfer       = |wb_valid;
      gnt        = wb_valid[rr] ? rr : wb_valid[p1] ? p1 : p2;
      wb_ready   = xfer ? {{(NREQ-1){1'b0}}, 1'b1} << gnt : '0;
      g_addr     = (gnt == 2'd0) ? wb_addr0 : (gnt == 2'd1) ? wb_addr1 : wb_addr2;
      g_data     = (gnt == 2'd0) ? wb_data0 : (gnt == 2'd1) ? wb_data1 : wb_data2;
      iss_ready  = !busy[iss_addr] || iss_addr == '0;
      raw_hazard = busy[chk_addr1] | busy[chk_addr2];
      set_m      = (iss_valid && iss_ready && iss_addr != '0) ? NREG'(1) << iss_addr : '0;
      clr_m      = (xfer && g_addr != '0) ? NREG'(1) << g_addr : '0;
   end
   // set is applied after clear so a same-edge claim survives the writeback
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr       <= 2'd0;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         busy     <= '0;
      end else begin
         rr    <= xfer ? ((gnt == 2'd2) ? 2'd0 : gnt + 2'd1) : rr;
         rf_we <= xfer && g_addr != '0;
         if (xfer) begin
            rf_waddr <= g_addr;
            rf_wdata <= g_data;
         end
         busy <= (busy & ~clr_m) | set_m;
      end
   end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and register scoreboard for the 64-entry unified register file (entries 0–31 integer x0–x31, 32–63 floating-point f0–f31). Three producers compete for the single register-file write port: ALU, FPU and LSU. The block grants one per cycle in round-robin order and drives a registered write port. It also tracks which destination registers have in-flight results, so decode can stall on RAW and WAW hazards.

## Interface
- DATA_W, 64, write-data width
- ADDR_W, 6, register address width (bit 5 = FP bank)
- NREQ, 3, number of producers; fixed at 3 (0 = ALU, 1 = FPU, 2 = LSU)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wb_valid  in  NREQ  producer i has a result
- wb_ready  out  NREQ  grant to producer i; transfer occurs when wb_valid[i] & wb_ready[i]
- wb_addr0/1/2  in  ADDR_W each  destination of producer 0/1/2
- wb_data0/1/2  in  DATA_W each  result of producer 0/1/2
- iss_valid  in  1  decode issues an instruction with destination iss_addr
- iss_addr  in  ADDR_W  destination being claimed
- iss_ready  out  1  issue accepted (destination free)
- chk_addr1, chk_addr2  in  ADDR_W  source operands of the instruction in decode
- raw_hazard  out  1  either source has a pending write
- rf_we  out  1  register-file write enable
- rf_waddr  out  ADDR_W  register-file write address
- rf_wdata  out  DATA_W  register-file write data

## Operation
- **Round-robin pointer `rr`** (0..2, reset 0):
  - Priority order is rr, rr+1, rr+2 (mod 3).
  - The first producer in that order with wb_valid is granted.
  - wb_ready is one-hot or zero, combinational from wb_valid and rr, and never asserted without the matching wb_valid.
  - On a transfer by producer g, rr becomes (g+1) mod 3; otherwise rr holds.
- **Output register**:
  - On a transfer, rf_waddr and rf_wdata load the granted address and data.
  - rf_we loads 1, except rf_we loads 0 when the address is 6'd0 (x0 is hardwired). f0 (address 32) is writable.
  - With no transfer, rf_we loads 0; rf_waddr and rf_wdata hold.
- **Scoreboard `busy[63:0]`** (reset all 0):
  - Set: iss_valid & iss_ready & iss_addr != 0 sets busy[iss_addr].
  - Clear: a transfer to address a != 0 clears busy[a] at the same edge the output register loads.
  - Set and clear of the same address on the same edge: set wins. This is unreachable while the WAW rule holds; the bench still checks it.
- **Issue and hazard rules**:
  - iss_ready = !busy[iss_addr] | (iss_addr == 0). A WAW stall keeps the first writeback from clearing a newer claim.
  - raw_hazard = busy[chk_addr1] | busy[chk_addr2], combinational from the current busy bits.
  - A result transferred this cycle does not clear its hazard until the next edge. No bypass is provided.
- **Invariant**: a writeback whose address is not busy is still written. The block does not police producers.
- **Reset mid-operation**: all busy bits, rr and rf_we go to 0 immediately; rf_waddr and rf_wdata go to 0. Any in-flight write is lost.

## Timing
- **Reset values**: wb_ready follows the combinational grant rule with rr = 0. iss_ready = 1. raw_hazard = 0.
- **Writeback latency**:
  - Transfer at edge E puts rf_we, rf_waddr and rf_wdata valid during cycle E→E+1.
  - The register file captures at edge E+1.
  - busy clears at E, so raw_hazard drops in cycle E→E+1.
  - The register file's asynchronous read returns the new value only after E+1. Decode must therefore add one cycle after raw_hazard falls, or the datapath forwards rf_wdata.
- **Throughput**: one write per cycle. A producer waiting with wb_valid high is granted within 3 cycles under full contention.
- **Ready path**: wb_ready depends only on wb_valid and rr, not on any wb_ready input path. Producers must hold valid, address and data stable until granted.

## Test plan
- **Reset and single write**:
  - Drive rst_n low and check that rf_we = 0, busy = 0, rr = 0 and iss_ready = 1.
  - Release reset, then ALU wb_valid with addr 5 and data 0xDEAD.
  - Require wb_ready = 3'b001 the same cycle, then rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEAD in the next cycle.
- **Full contention**:
  - Hold all three wb_valid high for 6 cycles.
  - Require the grant sequence 0,1,2,0,1,2, exactly one wb_ready per cycle, and rf_we high for 6 consecutive cycles.
- **x0 versus f0**:
  - A writeback to address 0 is granted, with rf_we = 0 the next cycle.
  - A writeback to address 32 gives rf_we = 1 and rf_waddr = 32.
  - Issue to address 0 leaves busy[0] = 0 and raw_hazard = 0 for chk_addr1 = 0.
- **RAW and WAW**:
  - Issue addr 40, then drive chk_addr2 = 40 and require raw_hazard = 1.
  - A second issue to 40 requires iss_ready = 0.
  - FPU writeback to 40 clears the hazard and iss_ready one edge after its transfer.
- **Reset mid-operation**:
  - Set busy on 3 registers and assert rst_n low asynchronously mid-cycle while the LSU is valid.
  - Require immediate rf_we = 0, busy = 0 and raw_hazard = 0, with rr = 0 after release.
